// File: rtl/uart_loader_ctrl.sv
// UART packet loader: WRITE packets go to memory one byte per req/ack handshake (req one cycle after the byte, held until ack); RUN releases cpu_hold.
// Trailing checksum byte is enabled by `define UART_LOADER_CHECKSUM_EN; bytes arriving while a write awaits ack are overruns.
module uart_loader_ctrl #(
  parameter logic [23:0] TIMEOUT_CLKS = 24'd2_147_700
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE, CMD, AHI, ALO, LEN, DATA, WAIT_ACK, CHK
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        req_q, req_d;
  logic        hold_q, hold_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [23:0] tmo_q, tmo_d;
  logic        timed;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]  sum_q, sum_d;
  logic [7:0]  chk_total;
  logic        run_q, run_d;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    req_d   = req_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    timed   = (state_q != IDLE) && (state_q != WAIT_ACK);
`ifdef UART_LOADER_CHECKSUM_EN
    sum_d     = sum_q;
    run_d     = run_q;
    chk_total = sum_q + rx_data;
    if (rx_valid && (state_q inside {AHI, ALO, LEN, DATA})) begin
      sum_d = sum_q + rx_data;
    end
`endif

    case (state_q)
      IDLE: begin
        if (rx_valid && rx_data == 8'hA5) begin
          state_d = CMD;
          err_d   = 1'b0;
        end
      end
      CMD: begin
        if (rx_valid) begin
`ifdef UART_LOADER_CHECKSUM_EN
          sum_d = rx_data;
`endif
          if (rx_data == 8'h01) begin
            state_d = AHI;
            hold_d  = 1'b1;
`ifdef UART_LOADER_CHECKSUM_EN
            run_d   = 1'b0;
`endif
          end else if (rx_data == 8'h02) begin
`ifdef UART_LOADER_CHECKSUM_EN
            state_d = CHK;
            run_d   = 1'b1;
`else
            state_d = IDLE;
            hold_d  = 1'b0;
            done_d  = 1'b1;
`endif
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
      end
      AHI: begin
        if (rx_valid) begin
          addr_d[15:8] = rx_data;
          state_d      = ALO;
        end
      end
      ALO: begin
        if (rx_valid) begin
          addr_d[7:0] = rx_data;
          state_d     = LEN;
        end
      end
      LEN: begin
        if (rx_valid) begin
          cnt_d   = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
          state_d = DATA;
        end
      end
      DATA: begin
        if (rx_valid) begin
          wdata_d = rx_data;
          req_d   = 1'b1;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (mem_ack && req_q) begin
          req_d  = 1'b0;
          addr_d = addr_q + 16'd1;
          cnt_d  = cnt_q - 9'd1;
          if (cnt_q == 9'd1) begin
`ifdef UART_LOADER_CHECKSUM_EN
            state_d = CHK;
`else
            state_d = IDLE;
            done_d  = 1'b1;
`endif
          end else begin
            state_d = DATA;
          end
        end
        // A byte here is an overrun even when the same-cycle ack finished the write.
        if (rx_valid) begin
          state_d = IDLE;
          req_d   = 1'b0;
          err_d   = 1'b1;
          done_d  = 1'b0;
        end
      end
`ifdef UART_LOADER_CHECKSUM_EN
      CHK: begin
        if (rx_valid) begin
          state_d = IDLE;
          if (chk_total == 8'd0) begin
            done_d = 1'b1;
            if (run_q) hold_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (timed && !rx_valid && tmo_q >= TIMEOUT_CLKS) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end

    if (rx_valid || (state_d != state_q) || !timed) begin
      tmo_d = 24'd0;
    end else begin
      tmo_d = tmo_q + 24'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= 16'd0;
      wdata_q <= 8'd0;
      req_q   <= 1'b0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 9'd0;
      tmo_q   <= 24'd0;
`ifdef UART_LOADER_CHECKSUM_EN
      sum_q   <= 8'd0;
      run_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      req_q   <= req_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
`ifdef UART_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
      run_q   <= run_d;
`endif
    end
  end

  assign mem_req   = req_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_hold  = hold_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;

endmodule
